// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/sequencing controller: FSM states,
// PC mux selects and EX-stage forwarding selects.
package pipeline_ctrl_pkg;

    localparam int unsigned REG_AW_DEF = 5;

    typedef logic [1:0] state_t;

    localparam state_t StIdle    = 2'b00;
    localparam state_t StRun     = 2'b01;
    localparam state_t StStall   = 2'b10;
    localparam state_t StMemWait = 2'b11;

    localparam logic [1:0] PC_SEL_INC    = 2'b00;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b10;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b11;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

endpackage

// File: rtl/forward_unit.sv
// EX-stage operand forwarding select for one source register.
// The younger EX/MEM producer wins over MEM/WB; r0 is never forwarded.
module forward_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic [REG_AW-1:0] mem_dst_i,
    input  logic              mem_reg_we_i,
    input  logic [REG_AW-1:0] wb_dst_i,
    input  logic              wb_reg_we_i,
    output logic [1:0]        sel_o
);

    always_comb begin
        sel_o = FWD_REG;
        if (src_i != '0) begin
            if (mem_reg_we_i && (mem_dst_i == src_i)) begin
                sel_o = FWD_EXMEM;
            end else if (wb_reg_we_i && (wb_dst_i == src_i)) begin
                sel_o = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencing for the 5-stage pipe: stalls, redirects, dmem freeze, forwarding.
// Optional PIPE_PERF_CNT_EN adds stall-cycle and flush performance counters.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW   = REG_AW_DEF,
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned WAIT_CW  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              id_branch,
    input  logic              id_jump,
    input  logic              id_taken,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              ex_reg_we,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic              mem_reg_we,
    input  logic              mem_mem_read,
    input  logic [REG_AW-1:0] wb_dst,
    input  logic              wb_reg_we,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic              pc_we,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              pipe_en,
    output logic [1:0]        pc_sel,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [1:0]        state_o,
    output logic              timeout_err
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles_o,
    output logic [31:0]       flush_cnt_o
`endif
);

    state_t             state_q, state_d;
    state_t             ret_q, ret_d;
    logic [WAIT_CW-1:0] wait_q, wait_d;
    logic [WAIT_CW-1:0] wait_inc;
    logic [1:0]         stall_cnt_q, stall_cnt_d;
    logic               timeout_q, timeout_d;

    logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic load_use, br_ex, br_mem, run_hold, dmem_busy;

    assign ex_hit_rs  = (ex_dst != '0) && (ex_dst == id_rs);
    assign ex_hit_rt  = (ex_dst != '0) && (ex_dst == id_rt);
    assign mem_hit_rs = (mem_dst != '0) && (mem_dst == id_rs);
    assign mem_hit_rt = (mem_dst != '0) && (mem_dst == id_rt);

    // beq always compares both rs and rt, so its operand checks ignore id_uses_rt.
    assign load_use = ex_mem_read && (ex_hit_rs || (id_uses_rt && ex_hit_rt));
    assign br_ex    = id_branch && ex_reg_we && (ex_hit_rs || ex_hit_rt);
    assign br_mem   = id_branch && mem_mem_read && (mem_hit_rs || mem_hit_rt);
    assign run_hold = load_use || br_ex || br_mem;

    assign dmem_busy = dmem_req && !dmem_ready;
    assign wait_inc  = wait_q + WAIT_CW'(1);

    always_comb begin
        pc_we       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_en     = 1'b0;
        pc_sel      = PC_SEL_INC;
        state_d     = state_q;
        ret_d       = ret_q;
        wait_d      = wait_q;
        stall_cnt_d = stall_cnt_q;
        timeout_d   = timeout_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                end
            end
            StRun, StStall: begin
                if (dmem_busy) begin
                    // Freeze this very cycle; remember where to resume.
                    ret_d   = state_q;
                    wait_d  = WAIT_CW'(1);
                    state_d = StMemWait;
                end else if (state_q == StRun) begin
                    pipe_en     = 1'b1;
                    pc_we       = !run_hold;
                    ifid_en     = !run_hold;
                    idex_bubble = run_hold;
                    if (!run_hold) begin
                        if (id_jump) begin
                            pc_sel     = PC_SEL_JUMP;
                            ifid_flush = 1'b1;
                        end else if (id_branch && id_taken) begin
                            pc_sel     = PC_SEL_BRANCH;
                            ifid_flush = 1'b1;
                        end
                    end
                    if (br_ex && ex_mem_read) begin
                        state_d     = StStall;
                        stall_cnt_d = 2'd1;
                    end
                end else begin
                    pipe_en     = 1'b1;
                    idex_bubble = 1'b1;
                    stall_cnt_d = stall_cnt_q - 2'd1;
                    if (stall_cnt_q <= 2'd1) begin
                        state_d = StRun;
                    end
                end
            end
            StMemWait: begin
                if (dmem_ready) begin
                    state_d = ret_q;
                    wait_d  = '0;
                end else if (wait_inc == WAIT_CW'(WAIT_MAX)) begin
                    timeout_d = 1'b1;
                    state_d   = StRun;
                    wait_d    = '0;
                end else begin
                    wait_d = wait_inc;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ret_q       <= StRun;
            wait_q      <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign state_o     = state_q;
    assign timeout_err = timeout_q;

    forward_unit #(
        .REG_AW(REG_AW)
    ) u_fwd_a (
        .src_i       (ex_rs),
        .mem_dst_i   (mem_dst),
        .mem_reg_we_i(mem_reg_we),
        .wb_dst_i    (wb_dst),
        .wb_reg_we_i (wb_reg_we),
        .sel_o       (fwd_a_sel)
    );

    forward_unit #(
        .REG_AW(REG_AW)
    ) u_fwd_b (
        .src_i       (ex_rt),
        .mem_dst_i   (mem_dst),
        .mem_reg_we_i(mem_reg_we),
        .wb_dst_i    (wb_dst),
        .wb_reg_we_i (wb_reg_we),
        .sel_o       (fwd_b_sel)
    );

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_cnt_q    <= '0;
        end else begin
            if ((state_q != StIdle) && !pc_we) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (ifid_flush) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_cnt_o    = flush_cnt_q;
`endif

endmodule
